// File: rtl/prng_stream_gen.sv
// Burst generator streaming NUM_CH parallel xorshift128+ lanes (or a counter pattern)
// over a valid/ready handshake, with abort, runtime reseed and completion pulse.
module prng_stream_gen #(
  parameter int unsigned NUM_CH = 2,
  parameter logic [63:0] SEED   = 64'd0,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [LEN_W-1:0]     i_len,
  input  logic                 i_mode,
  input  logic                 i_abort,
  input  logic                 i_reseed,
  input  logic [63:0]          i_seed,
  output logic [NUM_CH*64-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [LEN_W-1:0]     o_words
);

  localparam logic [63:0] Seed0Base = 64'he220a8397b1dcdaf;
  localparam logic [63:0] Seed1Base = 64'h6e789e6aa1b965f4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic             mode_q, mode_d;

  logic handshake;
  logic last_word;
  logic reseed_now;

  assign o_valid    = (state_q == StRun);
  assign o_busy     = (state_q != StIdle);
  assign o_done     = (state_q == StDone);
  assign o_words    = words_q;
  assign handshake  = o_valid && i_ready;
  assign last_word  = ((words_q + LEN_W'(1)) == len_q);
  assign reseed_now = (state_q == StIdle) && i_reseed;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    logic [63:0] s0_q, s1_q;
    logic [63:0] t1, n1, rnd, cnt;

    assign t1  = s0_q ^ (s0_q << 23);
    assign n1  = t1 ^ s1_q ^ (t1 >> 17) ^ (s1_q >> 26);
    assign rnd = n1 + s1_q;
    assign cnt = 64'(words_q) * 64'(NUM_CH) + 64'(g);

    assign o_data[64*g +: 64] = mode_q ? cnt : rnd;

    // Lanes advance on every handshake, even in counter mode, so the random
    // sequence position always tracks the number of words consumed.
    always_ff @(posedge clk) begin
      if (i_rst) begin
        s0_q <= Seed0Base + SEED + 64'(g);
        s1_q <= Seed1Base + SEED + 64'(g);
      end else if (reseed_now) begin
        s0_q <= Seed0Base + i_seed + 64'(g);
        s1_q <= Seed1Base + i_seed + 64'(g);
      end else if (handshake) begin
        s0_q <= s1_q;
        s1_q <= n1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    words_d = words_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          words_d = '0;
          len_d   = i_len;
          mode_d  = i_mode;
          state_d = (i_len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (handshake) words_d = words_q + LEN_W'(1);
        // Abort wins over a completing handshake: the word counts, no o_done.
        if (i_abort) begin
          state_d = StIdle;
        end else if (handshake && last_word) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      words_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      mode_q  <= mode_d;
    end
  end

endmodule
